ab_source: RTL

AB_SOURCE -- requirements
Module: ab_source

---
 rtl/ab_source_if.sv | 13 +
 rtl/ab_source.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ab_source_if.sv
// Operand/result handshake between ab_source and its consumer.
// The source side drives ACK/A/B; the consumer drives REQ_AB and the result word.
interface ab_source_if;
    logic        REQ_AB;
    logic        ACK;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] X;
    logic        X_VALID;

    modport master (input REQ_AB, X, X_VALID, output ACK, A, B);
    modport slave  (output REQ_AB, X, X_VALID, input ACK, A, B);
endinterface

// File: rtl/ab_source.sv
// Operand-pair source with programmable ACK latency, plus a result collector
// that buffers, counts and sums the words returned by the consumer.
module ab_source #(
    parameter int  NPAIR   = 8,
    parameter int  ACK_LAT = 0,
    localparam int IW      = $clog2(NPAIR)
) (
    input  logic          CLK,
    input  logic          RST,
    ab_source_if.master   ab,
    input  logic          LOAD_EN,
    input  logic [IW-1:0] LOAD_ADDR,
    input  logic [7:0]    LOAD_A,
    input  logic [7:0]    LOAD_B,
    input  logic          CLR,
    input  logic [IW-1:0] RD_ADDR,
    output logic [15:0]   RD_DATA,
    output logic [IW:0]   SENT_CNT,
    output logic [IW:0]   RES_CNT,
    output logic [15:0]   RES_SUM,
    output logic          OVF
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [IW:0] FULL   = (IW+1)'(NPAIR);
    localparam logic [3:0]  LAT_M1 = 4'(ACK_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [IW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IW:0]   sent_cnt_q, sent_cnt_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    op_a_q [NPAIR];
    logic [7:0]    op_a_d [NPAIR];
    logic [7:0]    op_b_q [NPAIR];
    logic [7:0]    op_b_d [NPAIR];

    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW:0]   res_cnt_q, res_cnt_d;
    logic [15:0]   res_sum_q, res_sum_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [15:0]   res_buf_q [NPAIR];
    logic [15:0]   res_buf_d [NPAIR];

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rd_ptr_d   = rd_ptr_q;
        sent_cnt_d = sent_cnt_q;
        a_d        = a_q;
        b_d        = b_q;

        if (state_q == S_ACK) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (sent_cnt_q != FULL) sent_cnt_d = sent_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_ACK: begin
                if (!ab.REQ_AB) begin
                    state_d = S_IDLE;
                end else if (ACK_LAT == 0) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = LAT_M1;
                end
            end
            S_WAIT: begin
                if (!ab.REQ_AB)       state_d = S_IDLE;
                else if (wait_q == '0) state_d = S_ACK;
                else                  wait_d  = wait_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (CLR) begin
            state_d    = S_IDLE;
            wait_d     = '0;
            rd_ptr_d   = '0;
            sent_cnt_d = '0;
        end

        // Pair is captured from the table as it stands before this edge's load
        if (state_d == S_ACK) begin
            a_d = op_a_q[rd_ptr_d];
            b_d = op_b_q[rd_ptr_d];
        end

        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (LOAD_EN) begin
            op_a_d[LOAD_ADDR] = LOAD_A;
            op_b_d[LOAD_ADDR] = LOAD_B;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        res_cnt_d = res_cnt_q;
        res_sum_d = res_sum_q;
        ovf_d     = ovf_q;
        res_buf_d = res_buf_q;
        rd_data_d = res_buf_q[RD_ADDR];

        if (CLR) begin
            wr_ptr_d  = '0;
            res_cnt_d = '0;
            res_sum_d = '0;
            ovf_d     = 1'b0;
        end else if (ab.X_VALID) begin
            if (res_cnt_q != FULL) begin
                res_buf_d[wr_ptr_q] = ab.X;
                wr_ptr_d            = wr_ptr_q + 1'b1;
                res_cnt_d           = res_cnt_q + 1'b1;
                res_sum_d           = res_sum_q + ab.X;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            rd_ptr_q   <= '0;
            sent_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_a_q     <= '{default: '0};
            op_b_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            res_cnt_q  <= '0;
            res_sum_q  <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            res_buf_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rd_ptr_q   <= rd_ptr_d;
            sent_cnt_q <= sent_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            wr_ptr_q   <= wr_ptr_d;
            res_cnt_q  <= res_cnt_d;
            res_sum_q  <= res_sum_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            res_buf_q  <= res_buf_d;
        end
    end

    assign ab.ACK   = (state_q == S_ACK);
    assign ab.A     = a_q;
    assign ab.B     = b_q;
    assign RD_DATA  = rd_data_q;
    assign SENT_CNT = sent_cnt_q;
    assign RES_CNT  = res_cnt_q;
    assign RES_SUM  = res_sum_q;
    assign OVF      = ovf_q;
endmodule
